// File: rtl/fft_peak_analyzer_if.sv
// Frame-input and result bundle for the FFT peak analyzer.
// The producer drives the frame, and the analyzer returns done, freq and overrun.
interface fft_peak_analyzer_if;
  logic        fft_valid;
  logic [31:0] fft_d0;
  logic [31:0] fft_d1;
  logic [31:0] fft_d2;
  logic [31:0] fft_d3;
  logic [31:0] fft_d4;
  logic [31:0] fft_d5;
  logic [31:0] fft_d6;
  logic [31:0] fft_d7;
  logic [31:0] fft_d8;
  logic [31:0] fft_d9;
  logic [31:0] fft_d10;
  logic [31:0] fft_d11;
  logic [31:0] fft_d12;
  logic [31:0] fft_d13;
  logic [31:0] fft_d14;
  logic [31:0] fft_d15;
  logic        done;
  logic [3:0]  freq;
  logic        overrun;

  modport master (
    output fft_valid, fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
           fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    input  done, freq, overrun
  );

  modport slave (
    input  fft_valid, fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
           fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    output done, freq, overrun
  );
endinterface

// File: rtl/fft_peak_analyzer.sv
// Captures a 16-bin complex frame and scans it two bins per cycle.
// It reports the index of the largest-magnitude bin, keeping the lower index on a tie.
module fft_peak_analyzer (
  input  logic               clk,
  input  logic               rst,
  fft_peak_analyzer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        capture_s;
  logic [31:0] din_s [16];
  logic [31:0] frame_r [16];
  logic [2:0]  step_r;
  logic [31:0] max_mag_r;
  logic [3:0]  max_idx_r;
  logic [31:0] max_mag_s;
  logic [3:0]  max_idx_s;
  logic [31:0] mag_lo_s;
  logic [31:0] mag_hi_s;
  logic [3:0]  freq_r;
  logic        done_r;
  logic        overrun_r;

  // Squares are taken on sign-extended 32-bit operands; |x|^2 <= 2^30, so the sum never exceeds 2^31.
  function automatic logic [31:0] bin_mag(input logic [31:0] word);
    logic [31:0] re_x;
    logic [31:0] im_x;
    re_x = {{16{word[31]}}, word[31:16]};
    im_x = {{16{word[15]}}, word[15:0]};
    return (re_x * re_x) + (im_x * im_x);
  endfunction

  assign din_s[0]  = bus.fft_d0;
  assign din_s[1]  = bus.fft_d1;
  assign din_s[2]  = bus.fft_d2;
  assign din_s[3]  = bus.fft_d3;
  assign din_s[4]  = bus.fft_d4;
  assign din_s[5]  = bus.fft_d5;
  assign din_s[6]  = bus.fft_d6;
  assign din_s[7]  = bus.fft_d7;
  assign din_s[8]  = bus.fft_d8;
  assign din_s[9]  = bus.fft_d9;
  assign din_s[10] = bus.fft_d10;
  assign din_s[11] = bus.fft_d11;
  assign din_s[12] = bus.fft_d12;
  assign din_s[13] = bus.fft_d13;
  assign din_s[14] = bus.fft_d14;
  assign din_s[15] = bus.fft_d15;

  assign bus.done    = done_r;
  assign bus.freq    = freq_r;
  assign bus.overrun = overrun_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and capture decision
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.fft_valid) begin
          state_s   = SCAN;
          capture_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (step_r == 3'd7) begin
          state_s = DONE;
        end else begin
          state_s = SCAN;
        end
      end
      DONE: begin
        if (bus.fft_valid) begin
          state_s   = SCAN;
          capture_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Running maximum over the current bin pair; the even bin is compared first so ties keep the lower index
  always_comb begin
    mag_lo_s  = bin_mag(frame_r[{step_r, 1'b0}]);
    mag_hi_s  = bin_mag(frame_r[{step_r, 1'b1}]);
    max_mag_s = max_mag_r;
    max_idx_s = max_idx_r;
    if (mag_lo_s > max_mag_s) begin
      max_mag_s = mag_lo_s;
      max_idx_s = {step_r, 1'b0};
    end else begin
      max_mag_s = max_mag_s;
    end
    if (mag_hi_s > max_mag_s) begin
      max_mag_s = mag_hi_s;
      max_idx_s = {step_r, 1'b1};
    end else begin
      max_mag_s = max_mag_s;
    end
  end

  // Frame buffer, scan datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      step_r    <= 3'd0;
      max_mag_r <= 32'd0;
      max_idx_r <= 4'd0;
      freq_r    <= 4'd0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      done_r    <= (state_r == DONE);
      overrun_r <= (state_r == SCAN) && bus.fft_valid;
      if (state_r == DONE) begin
        freq_r <= max_idx_r;
      end
      if (capture_s) begin
        for (int k = 0; k < 16; k++) begin
          frame_r[k] <= din_s[k];
        end
        step_r    <= 3'd0;
        max_mag_r <= 32'd0;
        max_idx_r <= 4'd0;
      end else if (state_r == SCAN) begin
        step_r    <= step_r + 3'd1;
        max_mag_r <= max_mag_s;
        max_idx_r <= max_idx_s;
      end
    end
  end

endmodule

// File: doc/fft_peak_analyzer.md
FFT_PEAK_ANALYZER -- requirements
Module: fft_peak_analyzer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port fft_valid, input, 1 bit: one-cycle strobe marking that fft_d0..fft_d15 hold a complete 16-bin frame.
REQ-004 SHALL have ports fft_d0..fft_d15, input, 32 bits each: bin k word; [31:16] real, [15:0] imag; both two's complement, 8 integer + 8 fraction bits.
REQ-005 SHALL have port done, output, 1 bit: one-cycle pulse, analysis of one frame complete.
REQ-006 SHALL have port freq, output, 4 bits: index of the bin with the largest magnitude in the last completed frame.
REQ-007 SHALL have port overrun, output, 1 bit: one-cycle pulse, a frame was dropped.

Function
REQ-008 SHALL implement states IDLE, SCAN, DONE.
REQ-009 SHALL capture all 16 words into an internal frame buffer on the edge where fft_valid=1 in IDLE or DONE, then enter SCAN with bin counter 0.
REQ-010 SHALL, in SCAN, process two bins per cycle (2k, 2k+1 at step k=0..7), completing in exactly 8 cycles.
REQ-011 SHALL compute mag = re*re + im*im per bin as unsigned 32 bits; no truncation, no saturation; max value 2^31 for {0x8000,0x8000}.
REQ-012 SHALL keep a running maximum magnitude and index; replace only if a new mag is strictly greater; ties keep the lower index.
REQ-013 SHALL clear the running maximum to 0 and index to 0 on each capture; an all-zero frame yields index 0.
REQ-014 SHALL, after step 7, enter DONE; done is high for exactly the one cycle spent in DONE; freq is updated on the same edge done rises.
REQ-015 SHALL hold freq between done pulses; it changes only on done or reset.
REQ-016 SHALL register done 9 clock edges after the capturing edge (capture edge E0 -> done high from E9 to E10).
REQ-017 SHALL return from DONE to IDLE unless fft_valid=1 in DONE, in which case capture and enter SCAN directly (back-to-back frames every 9 cycles are lossless).
REQ-018 SHALL ignore fft_valid in SCAN: buffer is not overwritten, the current scan is unaffected, and overrun pulses high for the next cycle.
REQ-019 SHALL never assert done and overrun for the same frame; a dropped frame produces no done.
REQ-020 SHALL use inputs only on the capturing edge; fft_d* may change freely at all other times.

Reset
REQ-021 SHALL, with rst=1 at a rising edge, force state IDLE, done=0, overrun=0, freq=0, running max=0, bin counter=0.
REQ-022 SHALL give rst priority over fft_valid on the same edge; that frame is not captured.
REQ-023 SHALL abort an in-progress scan on reset; no done for that frame; freq stays 0 until the next completed frame.

Verification
REQ-024 Single peak: bin5={0x0100,0x0000}, others 0, fft_valid at E0 -> done high E9..E10 only, freq=5.
REQ-025 Zero frame and tie: all bins 0 -> freq=0; then bins 3 and 12 = {0x0200,0x0000} -> freq=3.
REQ-026 Width corner: bin9={0x8000,0x8000} (mag 2^31), bin2={0x7FFF,0x7FFF} -> freq=9, no wraparound.
REQ-027 Overrun and back-to-back: frame A peak bin 7, fft_valid again at E4 -> overrun pulse, one done, freq=7; frame B (peak 14) with fft_valid in DONE cycle -> second done at E18, freq=14.
REQ-028 Reset mid-scan: rst=1 at E5 after capture -> no done, freq=0, state IDLE; next frame with peak bin 1 -> done 9 edges after its capture, freq=1.
